// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller.
//   state_t      - controller state encoding
//   LEN_*        - lsb_len encoding (byte count minus one)
//   IO_HI_DEFAULT- addr[17:16] value that marks an IO-mapped access
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_RSVD = 2'd2;
  localparam logic [1:0] LEN_WORD = 2'd3;

  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter for instruction fetch and load/store.
//   clk, rst (sync, active-high), rdy (global enable), roll_back (flush)
//   if_en/if_pc -> if_done/if_data          : 4-byte fetch
//   lsb_en/lsb_wr/lsb_addr/lsb_len/lsb_wdata -> lsb_done/lsb_rdata
//   mem_din/mem_dout/mem_a/mem_wr           : 1-byte-per-cycle RAM port
//   io_buffer_full                          : stalls stores to IO space
// Reads take N+1 busy cycles (the RAM returns data one cycle late), stores
// take N. Done pulses and returned data are registered; the RAM port is
// driven combinationally from the registered state so a stall on
// io_buffer_full takes effect in the same cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        roll_back,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] base;
  logic [31:0] wdata_r;
  logic [31:0] rbuf;
  logic [31:0] rd_next;
  logic        io_stall;

  // RAM port. In a read's final cycle (cnt == N) mem_a runs one past the
  // last byte; that read is harmless and keeps the address path simple.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state != IDLE) mem_a = base + 32'(cnt);
    io_stall = (mem_a[17:16] == IO_HI) && io_buffer_full;
    if (state == STORE) begin
      mem_dout = wdata_r[8*cnt[1:0] +: 8];
      mem_wr   = rdy && !io_stall;
    end
  end

  // mem_din carries the byte addressed in the previous cycle, i.e. byte cnt-1.
  always_comb begin
    rd_next = rbuf;
    for (int i = 0; i < 4; i++)
      if (cnt == 3'(i + 1)) rd_next[8*i +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      base      <= '0;
      wdata_r   <= '0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      lsb_done  <= 1'b0;
      if_data   <= '0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          // Requesters still hold en during the done cycle; skip it.
          if (!if_done && !lsb_done) begin
            if (lsb_en && !roll_back) begin
              state   <= lsb_wr ? STORE : LOAD;
              base    <= lsb_addr;
              nbytes  <= {1'b0, lsb_len} + 3'd1;
              wdata_r <= lsb_wdata;
              cnt     <= '0;
              rbuf    <= '0;
            end else if (if_en) begin
              state  <= FETCH;
              base   <= if_pc;
              nbytes <= FETCH_BYTES;
              cnt    <= '0;
              rbuf   <= '0;
            end
          end
        end
        FETCH, LOAD: begin
          if (state == LOAD && roll_back) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == nbytes) begin
            state <= IDLE;
            cnt   <= '0;
            if (state == FETCH) begin
              if_done <= 1'b1;
              if_data <= rd_next;
            end else begin
              lsb_done  <= 1'b1;
              lsb_rdata <= rd_next;
            end
          end else begin
            rbuf <= rd_next;
            cnt  <= cnt + 3'd1;
          end
        end
        STORE: begin
          if (!io_stall) begin
            if (cnt == nbytes - 3'd1) begin
              state    <= IDLE;
              cnt      <= '0;
              lsb_done <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_HI, default 2'b11: addr[17:16]==IO_HI marks an IO-mapped access.
REQ-002 clk  in  1  clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rdy  in  1  global enable; when low, no state changes.
REQ-005 roll_back  in  1  pipeline flush from ROB.
REQ-006 if_en  in  1  fetch request; held until if_done seen.
REQ-007 if_pc  in  32  fetch word address, bits[1:0]=0.
REQ-008 if_done  out  1  one-cycle fetch completion pulse.
REQ-009 if_data  out  32  fetched word; valid while if_done=1.
REQ-010 lsb_en  in  1  load/store request; held until lsb_done seen.
REQ-011 lsb_wr  in  1  1=store, 0=load.
REQ-012 lsb_addr  in  32  byte address.
REQ-013 lsb_len  in  2  0=1 byte, 1=2 bytes, 3=4 bytes; 2 reserved.
REQ-014 lsb_wdata  in  32  store data, little-endian, low bytes used.
REQ-015 lsb_done  out  1  one-cycle load/store completion pulse.
REQ-016 lsb_rdata  out  32  load data, zero-extended; valid while lsb_done=1.
REQ-017 mem_din  in  8  RAM read byte; reflects mem_a of previous cycle.
REQ-018 mem_dout  out  8  RAM write byte.
REQ-019 mem_a  out  32  RAM byte address.
REQ-020 mem_wr  out  1  1=write mem_dout to mem_a this cycle.
REQ-021 io_buffer_full  in  1  IO output buffer cannot accept a write.

Function
REQ-022 States SHALL be IDLE, FETCH, LOAD, STORE; current byte index cnt[2:0]; length N = lsb_len+1 for LSB, 4 for fetch.
REQ-023 In IDLE with if_done=0 and lsb_done=0, lsb_en SHALL win over if_en; accepted request latches addr/len/wdata and enters LOAD/STORE/FETCH at the next edge.
REQ-024 In IDLE during a cycle where if_done or lsb_done is 1, no request SHALL be accepted (requester drops en one cycle after done).
REQ-025 Read (FETCH/LOAD): in busy cycle k (k=0..N-1) mem_a=base+k, mem_wr=0; byte k-1 sampled from mem_din in cycle k; byte N-1 sampled in cycle N.
REQ-026 Read completion: at end of cycle N, data[8i+7:8i]=byte i assembled, done driven high in cycle N+1 for exactly one cycle, state returns to IDLE at the same edge.
REQ-027 Store: in cycle k mem_a=base+k, mem_dout=wdata[8k+7:8k], mem_wr=1; lsb_done high in the cycle after byte N-1 written.
REQ-028 Store to IO address with io_buffer_full=1 SHALL stall: mem_wr=0, cnt held, until io_buffer_full=0.
REQ-029 mem_wr SHALL be 0 in every cycle not writing a store byte; mem_a=0 in IDLE.
REQ-030 roll_back during LOAD SHALL abort to IDLE with no lsb_done; roll_back SHALL NOT affect FETCH or STORE in progress, nor IDLE acceptance of if_en.
REQ-031 roll_back in the same cycle as lsb_en acceptance SHALL suppress acceptance of the LSB request.
REQ-032 Address arithmetic SHALL be 32-bit wrap-around; no alignment checking.
REQ-033 rdy=0 SHALL freeze all state; mem_wr forced 0 while rdy=0.

Reset
REQ-034 rst SHALL set state=IDLE, cnt=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, mem_a=0, mem_dout=0, mem_wr=0; rst mid-transfer abandons it with no done pulse.

Structure
REQ-035 Shared package mem_ctrl_pkg SHALL hold state encoding, lsb_len encoding, and IO_HI default.
REQ-036 Single module; no sub-module.

Verification
REQ-037 Fetch: if_en=1, if_pc=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x100..0x103 in 4 cycles, if_done one pulse with if_data=0x00000513 in cycle 5.
REQ-038 Arbitration: if_en and lsb_en (load, len=0, addr 0x200, byte 0xFF) same cycle -> load first, lsb_rdata=0x000000FF, then fetch starts only after done-cooldown cycle.
REQ-039 Store: lsb_wr=1, len=1, addr 0x400, wdata 0xAABBCCDD -> writes 0xDD@0x400, 0xCC@0x401, mem_wr high exactly 2 cycles, lsb_done one pulse.
REQ-040 IO stall: store len=0 to 0x30000, io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one write, then lsb_done.
REQ-041 Flush: roll_back in cycle 2 of 4-byte load -> no lsb_done, IDLE next cycle; roll_back during fetch -> if_done still delivered.
REQ-042 Reset: rst asserted mid-store -> all outputs zero next cycle, no done pulse.
